// File: rtl/sram_like_ram_slave.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : sram_like_ram_slave
// Brief    : sram-like bus responder backed by a word RAM; fixed-latency,
//            in-order responses through a small outstanding-request queue.
// Revision : 1.0 - initial release
// ============================================================================
module sram_like_ram_slave #(
    parameter int ADDR_WIDTH   = 10,
    parameter int RESP_LATENCY = 2,
    parameter int QUEUE_DEPTH  = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic [31:0] rdata,
    output logic        data_ok
);

    localparam int                 c_CNT_W     = $clog2(QUEUE_DEPTH + 1);
    localparam int                 c_TMR_W     = 3;
    localparam int                 c_MEM_WORDS = 1 << ADDR_WIDTH;
    localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(QUEUE_DEPTH);
    localparam logic [c_TMR_W-1:0] c_TMR_LOAD  = c_TMR_W'(RESP_LATENCY - 1);

    logic [31:0]           mem [c_MEM_WORDS];
    logic [ADDR_WIDTH-1:0] word_idx;
    logic [3:0]            be;
    logic [31:0]           rd_word;
    logic                  push;
    logic                  pop;
    logic [c_CNT_W-1:0]    cnt_pop;
    logic                  unused_addr_hi;

    logic [c_CNT_W-1:0]    count_q, count_d;
    logic                  isw_q  [QUEUE_DEPTH];
    logic                  isw_d  [QUEUE_DEPTH];
    logic [31:0]           data_q [QUEUE_DEPTH];
    logic [31:0]           data_d [QUEUE_DEPTH];
    logic [c_TMR_W-1:0]    tmr_q  [QUEUE_DEPTH];
    logic [c_TMR_W-1:0]    tmr_d  [QUEUE_DEPTH];
    logic                  data_ok_q, data_ok_d;
    logic [31:0]           rdata_q, rdata_d;

    function automatic logic [c_TMR_W-1:0] tick(input logic [c_TMR_W-1:0] t);
        return (t != '0) ? t - c_TMR_W'(1) : t;
    endfunction

    // Upper address bits alias onto the same words.
    assign word_idx       = addr[ADDR_WIDTH+1:2];
    assign unused_addr_hi = ^addr[31:ADDR_WIDTH+2];

    always_comb begin
        case (size)
            2'b00:   be = 4'b0001 << addr[1:0];
            2'b01:   be = addr[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
    end

    // Slot availability comes from registered state only; a pop this cycle does not count.
    assign addr_ok = !reset && (count_q < c_DEPTH_CNT);
    assign push    = req && addr_ok;
    assign pop     = data_ok_q;
    assign rd_word = mem[word_idx];

    always_ff @(posedge clock) begin
        if (push && wr) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[word_idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            isw_d[i]  = isw_q[i];
            data_d[i] = data_q[i];
            tmr_d[i]  = tick(tmr_q[i]);
        end
        if (pop) begin
            for (int i = 0; i < QUEUE_DEPTH - 1; i++) begin
                isw_d[i]  = isw_q[i+1];
                data_d[i] = data_q[i+1];
                tmr_d[i]  = tick(tmr_q[i+1]);
            end
            isw_d[QUEUE_DEPTH-1]  = 1'b0;
            data_d[QUEUE_DEPTH-1] = '0;
            tmr_d[QUEUE_DEPTH-1]  = '0;
        end
        cnt_pop = count_q - c_CNT_W'(pop);
        count_d = cnt_pop;
        if (push) begin
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                if (c_CNT_W'(i) == cnt_pop) begin
                    isw_d[i]  = wr;
                    data_d[i] = wr ? 32'h0 : rd_word;
                    tmr_d[i]  = c_TMR_LOAD;
                end
            end
            count_d = cnt_pop + c_CNT_W'(1);
        end
        // Response flag is registered from the head entry as it will stand after this edge.
        data_ok_d = (count_d != '0) && (tmr_d[0] == '0);
        rdata_d   = (data_ok_d && !isw_d[0]) ? data_d[0] : 32'h0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q   <= '0;
            data_ok_q <= 1'b0;
            rdata_q   <= '0;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                isw_q[i]  <= 1'b0;
                data_q[i] <= '0;
                tmr_q[i]  <= '0;
            end
        end else begin
            count_q   <= count_d;
            data_ok_q <= data_ok_d;
            rdata_q   <= rdata_d;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                isw_q[i]  <= isw_d[i];
                data_q[i] <= data_d[i];
                tmr_q[i]  <= tmr_d[i];
            end
        end
    end

    assign data_ok = data_ok_q && !reset;
    assign rdata   = reset ? 32'h0 : rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_sram_like_ram_slave.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_sram_like_ram_slave
// Brief    : Randomised scoreboard bench for sram_like_ram_slave.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_like_ram_slave;

    localparam int AW    = 10;
    localparam int L     = 2;
    localparam int QD    = 2;
    localparam int WORDS = 1 << AW;

    logic        clock = 1'b0;
    logic        reset;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic [31:0] rdata;
    logic        data_ok;

    sram_like_ram_slave #(
        .ADDR_WIDTH  (AW),
        .RESP_LATENCY(L),
        .QUEUE_DEPTH (QD)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .req    (req),
        .wr     (wr),
        .size   (size),
        .addr   (addr),
        .wdata  (wdata),
        .addr_ok(addr_ok),
        .rdata  (rdata),
        .data_ok(data_ok)
    );

    always #5 clock = ~clock;

    int edge_cnt = 0;
    always @(posedge clock) edge_cnt <= edge_cnt + 1;

    typedef struct {
        int          due;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [31:0] ref_mem [WORDS];
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, want, edge_cnt);
        end
    endtask

    // Reference: byte-addressed RAM with aliasing, response due L cycles after the accept cycle.
    task automatic model_accept(input logic w, input logic [1:0] sz,
                                input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        int   idx;
        bit   st;
        idx   = int'((a / 4) % WORDS);
        e.due = edge_cnt + L;
        if (w) begin
            for (int b = 0; b < 4; b++) begin
                case (sz)
                    2'd0:    st = (b == int'(a % 4));
                    2'd1:    st = ((b / 2) == int'((a / 2) % 2));
                    default: st = 1'b1;
                endcase
                if (st) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
            end
            e.data = 32'h0;
        end else begin
            e.data = ref_mem[idx];
        end
        sb.push_back(e);
    endtask

    task automatic drive(input logic rs, input logic r, input logic w, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] d, output bit acc);
        @(negedge clock);
        #1;
        reset = rs; req = r; wr = w; size = sz; addr = a; wdata = d;
        #3;
        acc = 1'b0;
        if (reset) begin
            sb.delete();
        end else if (req && addr_ok) begin
            acc = 1'b1;
            model_accept(w, sz, a, d);
        end
    endtask

    task automatic do_req(input logic w, input logic [1:0] sz, input logic [31:0] a,
                          input logic [31:0] d);
        bit acc;
        int n;
        n = 0;
        do begin
            drive(1'b0, 1'b1, w, sz, a, d, acc);
            n++;
        end while (!acc && n < 20);
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got no addr_ok expected accept within 20 cycles");
        end
    endtask

    task automatic idle(input int n);
        bit acc;
        repeat (n) drive(1'b0, 1'b0, 1'b0, 2'b10, 32'h0, 32'h0, acc);
    endtask

    always @(negedge clock) begin
        chk("addr_ok", {31'h0, addr_ok}, {31'h0, (!reset && sb.size() < QD)});
        if (data_ok) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_data_ok: got data_ok=1 rdata=%h expected no response", rdata);
            end else begin
                mon_e = sb.pop_front();
                chk("data_ok_cycle", edge_cnt, mon_e.due);
                chk("rdata", rdata, mon_e.data);
            end
        end else begin
            chk("rdata_idle", rdata, 32'h0);
            if (sb.size() > 0 && sb[0].due <= edge_cnt) begin
                checks++;
                errors++;
                $display("FAIL missing_data_ok: got data_ok=0 expected response due at edge %0d", sb[0].due);
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        bit acc;
        int n;
        for (int i = 0; i < WORDS; i++) ref_mem[i] = 32'h0;
        reset = 1'b1; req = 1'b1; wr = 1'b0; size = 2'b10; addr = 32'h0; wdata = 32'h0;

        repeat (3) drive(1'b1, 1'b1, 1'b0, 2'b10, 32'h0, 32'h0, acc);
        idle(1);

        for (int i = 0; i < 16; i++) do_req(1'b1, 2'b10, 32'h40 + 32'(4 * i), $urandom);
        idle(2);

        do_req(1'b1, 2'b10, 32'h10, 32'hDEADBEEF);
        do_req(1'b0, 2'b10, 32'h10, 32'h0);
        idle(3);

        do_req(1'b1, 2'b10, 32'h20, 32'h11223344);
        do_req(1'b1, 2'b00, 32'h23, 32'hAA000000);
        do_req(1'b1, 2'b01, 32'h20, 32'h00005566);
        do_req(1'b0, 2'b10, 32'h20, 32'h0);
        do_req(1'b1, 2'b10, 32'h20 + 32'(4 * WORDS), 32'h11223344);
        do_req(1'b1, 2'b00, 32'h23 + 32'(4 * WORDS), 32'hBB000000);
        do_req(1'b1, 2'b01, 32'h21 + 32'(4 * WORDS), 32'h00007788);
        do_req(1'b0, 2'b10, 32'h20, 32'h0);
        idle(4);

        for (int i = 0; i < 6; i++) do_req(1'b0, 2'b10, 32'h40 + 32'(4 * i), 32'h0);
        idle(5);

        do_req(1'b0, 2'b10, 32'h44, 32'h0);
        do_req(1'b0, 2'b10, 32'h48, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 2'b10, 32'h0, 32'h0, acc);
        idle(3);
        do_req(1'b0, 2'b10, 32'h10, 32'h0);
        idle(4);

        for (int k = 0; k < 150; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                idle(1);
            end else begin
                do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                       32'h40 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3))
                       + (32'($urandom_range(0, 3)) << (AW + 2)),
                       $urandom);
            end
        end

        n = 0;
        while (sb.size() > 0 && n < 20) begin
            idle(1);
            n++;
        end
        idle(1);
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d outstanding expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
